// File: rtl/dac_sample_sequencer.sv
// Sample engine for the 10-bit DAC macro: 16-entry sample FIFO, per-period pop to dac_sel,
// and the IDLE -> RESET -> WARMUP -> RUN power-up sequence on the macro's RST/EN pins.
module dac_sample_sequencer #(
    parameter int FIFO_AW       = 4,
    parameter int RST_CYCLES    = 8,
    parameter int WARMUP_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [9:0]         wr_data,
    input  logic [15:0]        period,
    input  logic [FIFO_AW:0]   fifo_th,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic               below_th,
    output logic               underflow,
    output logic               overflow,
    output logic               sample_tick,
    output logic [9:0]         dac_sel,
    output logic               dac_en,
    output logic               dac_rst,
    output logic [1:0]         fsm_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RESET  = 2'd1;
    localparam logic [1:0] ST_WARMUP = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam int                 DEPTH       = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   LVL_FULL    = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   LVL_ONE     = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE     = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [15:0]        RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0]        WARMUP_LAST = 16'(WARMUP_CYCLES - 1);

    logic [1:0]         state;
    logic [15:0]        phase_cnt;
    logic [15:0]        period_cnt;
    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               tick;
    logic               do_pop;
    logic               do_push;

    // Push protocol: wr_en is a fire-and-forget strobe with no back-pressure; a push that
    // finds the FIFO full (and no pop freeing a slot on the same edge) is dropped and flagged.
    assign tick    = (state == ST_RUN) && (period_cnt == period);
    assign do_pop  = tick && !fifo_empty && !flush;
    assign do_push = wr_en && !flush && (!fifo_full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase_cnt <= 16'd0;
        end else if (!en) begin
            state     <= ST_IDLE;
            phase_cnt <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state     <= ST_RESET;
                    phase_cnt <= 16'd0;
                end
                ST_RESET: begin
                    if (phase_cnt == RST_LAST) begin
                        state     <= ST_WARMUP;
                        phase_cnt <= 16'd0;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                ST_WARMUP: begin
                    if (phase_cnt == WARMUP_LAST) begin
                        state     <= ST_RUN;
                        phase_cnt <= 16'd0;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                ST_RUN:  phase_cnt <= 16'd0;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Held at 0 outside RUN so the first compare lands period+1 clocks after RUN entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= 16'd0;
        end else if (state != ST_RUN) begin
            period_cnt <= 16'd0;
        end else if (period_cnt == period) begin
            period_cnt <= 16'd0;
        end else begin
            period_cnt <= period_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pulses are registered so sample_tick is high in the same cycle dac_sel shows the new sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_sel     <= 10'd0;
            sample_tick <= 1'b0;
            underflow   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            sample_tick <= do_pop;
            underflow   <= tick && fifo_empty && !flush;
            overflow    <= wr_en && !flush && fifo_full && !do_pop;
            if (do_pop) dac_sel <= mem[rd_ptr];
        end
    end

    assign fifo_level = level;
    assign fifo_full  = (level == LVL_FULL);
    assign fifo_empty = (level == '0);
    assign below_th   = (level < fifo_th);
    assign dac_en     = (state != ST_IDLE);
    assign dac_rst    = (state == ST_IDLE) || (state == ST_RESET);
    assign fsm_state  = state;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Bench for dac_sample_sequencer: fill table, power-up/timing sequences, and a randomized run
// checked every cycle against a queue-based model of the FIFO and an elapsed-cycle phase model.
module tb_dac_sample_sequencer;

    localparam int RST_CYC  = 8;
    localparam int WARM_CYC = 32;
    localparam int RUN_AT   = 1 + RST_CYC + WARM_CYC;  // enabled edges before the first RUN cycle
    localparam int DEPTH    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_data = 10'd0;
    logic [15:0] period = 16'd0;
    logic [4:0]  fifo_th = 5'd0;
    logic [4:0]  fifo_level;
    logic        fifo_full, fifo_empty, below_th, underflow, overflow, sample_tick;
    logic [9:0]  dac_sel;
    logic        dac_en, dac_rst;
    logic [1:0]  fsm_state;

    dac_sample_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .period(period), .fifo_th(fifo_th), .fifo_level(fifo_level), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .below_th(below_th), .underflow(underflow), .overflow(overflow),
        .sample_tick(sample_tick), .dac_sel(dac_sel), .dac_en(dac_en), .dac_rst(dac_rst),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model
    logic [9:0] exp_q[$];
    int         en_cnt;
    logic [9:0] m_sel;
    bit         m_stick, m_uf, m_of;
    int         n_vec, n_miss;

    task automatic model_reset();
        exp_q.delete();
        en_cnt  = 0;
        m_sel   = 10'd0;
        m_stick = 1'b0;
        m_uf    = 1'b0;
        m_of    = 1'b0;
    endtask

    task automatic model_edge();
        int p;
        bit tick;
        p    = int'(period);
        tick = (en_cnt >= RUN_AT) && (((en_cnt - RUN_AT) % (p + 1)) == p);
        m_stick = 1'b0;
        m_uf    = 1'b0;
        m_of    = 1'b0;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (tick) begin
                if (exp_q.size() > 0) begin
                    m_sel   = exp_q.pop_front();
                    m_stick = 1'b1;
                end else begin
                    m_uf = 1'b1;
                end
            end
            if (wr_en) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(wr_data);
                else m_of = 1'b1;
            end
        end
        en_cnt = en ? en_cnt + 1 : 0;
    endtask

    // scoreboard
    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        cmp("level", int'(fifo_level), exp_q.size());
        cmp("full", int'(fifo_full), int'(exp_q.size() == DEPTH));
        cmp("empty", int'(fifo_empty), int'(exp_q.size() == 0));
        cmp("below_th", int'(below_th), int'(exp_q.size() < int'(fifo_th)));
        cmp("underflow", int'(underflow), int'(m_uf));
        cmp("overflow", int'(overflow), int'(m_of));
        cmp("sample_tick", int'(sample_tick), int'(m_stick));
        cmp("dac_sel", int'(dac_sel), int'(m_sel));
        cmp("dac_en", int'(dac_en), int'(en_cnt > 0));
        cmp("dac_rst", int'(dac_rst), int'(en_cnt <= RST_CYC));
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0; wr_en = 1'b0; fifo_th = 5'd0; period = 16'd0;
        #1;
        model_reset();
        check_all();
        cmp("rst_dac_rst", int'(dac_rst), 1);
        cmp("rst_dac_en", int'(dac_en), 0);
        cmp("rst_dac_sel", int'(dac_sel), 0);
        cmp("rst_empty", int'(fifo_empty), 1);
        cmp("rst_level", int'(fifo_level), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       en_i;
        logic       flush_i;
        logic       wr_i;
        logic [9:0] data;
        logic [4:0] th;
        int         lvl;
        logic       full;
        logic       empty;
        logic       below;
        logic       ovf;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int tick_idx[$];
        int tick_val[$];
        int uf_idx[$];
        int first_rst_low, below_rise, lvl_at_rise;
        bit prev_below, ok_en;
        int p_opts[5];

        n_vec = 0;
        n_miss = 0;
        p_opts = '{0, 1, 2, 3, 7};

        for (int k = 0; k < 16; k++)
            tbl[k] = '{1'b0, 1'b0, 1'b1, 10'(k + 1), 5'd8, k + 1, (k == 15), 1'b0, ((k + 1) < 8), 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 10'd17, 5'd8,  16, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 10'd0,  5'd16, 16, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 10'd0,  5'd17, 16, 1'b1, 1'b0, 1'b1, 1'b0};

        do_reset();

        // Fill 17 words while disabled: 17th is dropped with an overflow pulse.
        for (int k = 0; k < 19; k++) begin
            en = tbl[k].en_i; flush = tbl[k].flush_i; wr_en = tbl[k].wr_i;
            wr_data = tbl[k].data; fifo_th = tbl[k].th;
            step();
            cmp("tbl_level", int'(fifo_level), tbl[k].lvl);
            cmp("tbl_full", int'(fifo_full), int'(tbl[k].full));
            cmp("tbl_empty", int'(fifo_empty), int'(tbl[k].empty));
            cmp("tbl_below", int'(below_th), int'(tbl[k].below));
            cmp("tbl_ovf", int'(overflow), int'(tbl[k].ovf));
        end

        // Full FIFO, period 0: simultaneous push and pop keeps level at 16; first pop is word 1.
        wr_en = 1'b0; period = 16'd0; fifo_th = 5'd8; en = 1'b1;
        repeat (RUN_AT) step();
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 10'(100 + i);
            step();
            cmp("pp_level", int'(fifo_level), 16);
            cmp("pp_ovf", int'(overflow), 0);
            cmp("pp_sel", int'(dac_sel), i + 1);
        end
        wr_en = 1'b0; flush = 1'b1;
        step();
        cmp("flush_level", int'(fifo_level), 0);
        cmp("flush_sel", int'(dac_sel), 6);
        cmp("flush_uf", int'(underflow), 0);
        flush = 1'b0;
        step();
        cmp("post_flush_uf", int'(underflow), 1);
        cmp("post_flush_sel", int'(dac_sel), 6);
        en = 1'b0;
        step();

        // Push 1..10, period 16: power-up timing, sample spacing, underflow, threshold crossing.
        do_reset();
        wr_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wr_data = 10'(i);
            step();
        end
        wr_en = 1'b0; period = 16'd16; fifo_th = 5'd8; en = 1'b1;
        first_rst_low = -1; below_rise = -1; lvl_at_rise = -1; prev_below = below_th;
        for (int i = 1; i <= 250; i++) begin
            step();
            if (!dac_rst && first_rst_low < 0) first_rst_low = i;
            if (sample_tick) begin
                tick_idx.push_back(i);
                tick_val.push_back(int'(dac_sel));
            end
            if (underflow) uf_idx.push_back(i);
            if (below_th && !prev_below && below_rise < 0) begin
                below_rise  = i;
                lvl_at_rise = int'(fifo_level);
            end
            prev_below = below_th;
        end
        cmp("rst_phase_len", first_rst_low, RST_CYC + 1);
        cmp("n_ticks", tick_idx.size(), 10);
        for (int k = 0; k < 10 && k < tick_idx.size(); k++) begin
            cmp("tick_time", tick_idx[k], RUN_AT + 17 + 17 * k);
            cmp("tick_val", tick_val[k], k + 1);
        end
        cmp("n_underflow", uf_idx.size(), 2);
        for (int k = 0; k < 2 && k < uf_idx.size(); k++)
            cmp("uf_time", uf_idx[k], RUN_AT + 17 + 170 + 17 * k);
        cmp("below_rise_time", below_rise, RUN_AT + 17 + 34);
        cmp("below_rise_level", lvl_at_rise, 7);

        // Drop en during warmup, then re-enable: full 8+32 sequence again.
        en = 1'b0;
        step();
        en = 1'b1;
        repeat (20) step();
        cmp("warm_rst_low", int'(dac_rst), 0);
        en = 1'b0;
        step();
        cmp("abort_dac_en", int'(dac_en), 0);
        cmp("abort_dac_rst", int'(dac_rst), 1);
        en = 1'b1;
        first_rst_low = -1; ok_en = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            step();
            if (!dac_rst && first_rst_low < 0) first_rst_low = i;
            if (!dac_en) ok_en = 1'b0;
        end
        cmp("reenable_rst_len", first_rst_low, RST_CYC + 1);
        cmp("reenable_dac_en", int'(ok_en), 1);
        en = 1'b0;
        step();

        // Randomized traffic; period only changes while the sequencer is idle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (en) begin
                if ($urandom_range(0, 399) == 0) en = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                en = 1'b1;
            end
            if (!en && en_cnt == 0) period = 16'(p_opts[$urandom_range(0, 4)]);
            wr_en   = ($urandom_range(0, 99) < 45);
            wr_data = 10'($urandom_range(0, 1023));
            flush   = ($urandom_range(0, 99) < 2);
            fifo_th = 5'($urandom_range(0, 17));
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                #2;
                model_reset();
                check_all();
                @(negedge clk);
                rst = 1'b0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dac_sample_sequencer.md
Name: dac_sample_sequencer

Overview:
Core sample engine between the DAC bus wrapper's register file and the 10-bit DAC analog macro. It buffers 10-bit samples written by the bus side in a FIFO. It pops one sample per programmable sample period and drives the DAC select lines. It sequences the macro's RST/EN pins through power-up and reports FIFO status and error events to the wrapper's interrupt logic.

Parameters:
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries
RST_CYCLES, 8, clocks dac_rst is held high on enable
WARMUP_CYCLES, 32, clocks after reset release before the first sample is popped

Ports:
clk  input  1  system clock (same as bus HCLK)
rst  input  1  asynchronous active-high reset
en  input  1  controller enable (CTRL bit 0)
flush  input  1  single-cycle FIFO clear
wr_en  input  1  push wr_data (one per cycle max)
wr_data  input  10  sample value
period  input  16  sample period in clocks minus 1 (0 = every clock)
fifo_th  input  FIFO_AW+1  level threshold
fifo_level  output  FIFO_AW+1  current entry count, 0..16
fifo_full  output  1  level == 16
fifo_empty  output  1  level == 0
below_th  output  1  level < fifo_th (level-type IRQ source)
underflow  output  1  1-cycle pulse: sample tick while FIFO empty
overflow  output  1  1-cycle pulse: wr_en while full (data dropped)
sample_tick  output  1  1-cycle pulse when dac_sel updates
dac_sel  output  10  to SELD9..SELD0
dac_en  output  1  to macro EN
dac_rst  output  1  to macro RST

Behaviour:
- Reset: FIFO empty; fifo_level=0; dac_sel=0; dac_en=0; dac_rst=1; all pulses 0; FSM=IDLE; period counter 0.
- FSM states:
  - IDLE: dac_en=0, dac_rst=1. Goes to RESET when en=1.
  - RESET: dac_en=1, dac_rst=1 for RST_CYCLES clocks, then WARMUP.
  - WARMUP: dac_en=1, dac_rst=0 for WARMUP_CYCLES clocks, then RUN.
  - RUN: dac_en=1, dac_rst=0.
  - en=0 in any state returns to IDLE on the next clock. dac_sel is held and the FIFO content is kept.
- Period counter: runs only in RUN. Reloads to 0 on RUN entry. A tick fires when the counter == period, then the counter wraps to 0. With period=N, ticks are exactly N+1 clocks apart. The first tick comes N+1 clocks after RUN entry.
- On a tick with FIFO non-empty: pop the head, register dac_sel = head on the same edge, assert sample_tick for that cycle.
- On a tick with FIFO empty: dac_sel holds its last value, underflow pulses, sample_tick stays 0.
- Push: when wr_en=1 and not full, write at the tail. When wr_en=1 and full, drop the data and pulse overflow.
- Simultaneous push and pop when full: both allowed, level unchanged, no overflow (the pop frees the slot in the same cycle).
- Simultaneous push and pop when empty: pop is not performed (underflow pulses) and the push succeeds.
- Level: +1 on push only, -1 on pop only, unchanged on both. Pointers wrap modulo 16.
- flush: empties the FIFO (pointers and level = 0) with priority over a push or pop in the same cycle. Emits no overflow or underflow. dac_sel is unchanged.
- Status outputs are combinational from the level register and valid in the same cycle.
- period changed mid-run takes effect at the next compare. If the new period is below the current count, the counter runs to 0xFFFF and wraps, which is documented as permitted.
- Async rst mid-operation returns everything to the reset values immediately.

Test Plan:
- Reset then idle: dac_rst=1, dac_en=0, dac_sel=0, fifo_empty=1, fifo_level=0.
- Push 1..10, period=16, en=1: dac_rst high for 8 clocks, then 32 clocks of warmup. First sample_tick 17 clocks after RUN entry. dac_sel steps 1,2,...,10 at 17-clock spacing, then underflow pulses every 17 clocks with dac_sel holding 10.
- Push 17 words with en=0: level=16, fifo_full=1, one overflow pulse on the 17th push, and the first popped value after enabling is word 1.
- fifo_th=8, level 10 draining: below_th goes 0→1 exactly in the cycle level becomes 7.
- Full FIFO, period=0, push and pop in the same cycle: level stays 16, no overflow. Then flush: level=0, dac_sel unchanged.
- en deasserted in WARMUP: FSM back to IDLE next clock with dac_en=0 and dac_rst=1. Re-enabling repeats the full 8+32 sequence.
